boreal_dma_mem_resp: RTL and testbench
======================================

# boreal_dma_mem_resp

Dual-port memory responder: the target end of the DMA ring engine's mem_sel/mem_wr/mem_addr interface. It arbitrates between that DMA port and a host port, owns a single-ported word SRAM array, and answers every accepted request with a one-cycle ready pulse after a programmable latency. It sits between the DMA ring engine and the shared descriptor/data scratchpad.

## Interface
- MEM_DEPTH, 1024: number of 32-bit words implemented; legal addresses are 0..MEM_DEPTH-1.
- LAT, 2: cycles from request acceptance to ready pulse; legal range 1..15.
- ERR_WORD, 32'hDEAD_BEEF: read data returned for out-of-range reads.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_sel  in  1  DMA request valid.
- mem_wr  in  1  DMA request is a write (1) or a read (0).
- mem_addr  in  10  DMA word address.
- mem_wdata  in  32  DMA write data.
- mem_ready  out  1  one-cycle completion pulse to DMA.
- mem_rdata  out  32  DMA read data; valid while mem_ready=1.
- mem_err  out  1  with mem_ready: address was out of range.
- host_sel, host_wr, host_addr[9:0], host_wdata[31:0]  in  host request, same meaning as the DMA fields.
- host_ready, host_rdata[31:0], host_err  out  host completion, same meaning as the DMA fields.
- busy  out  1  high whenever state is not IDLE.

## Operation
- Request protocol, per port: the initiator raises sel with wr, addr, and wdata, and holds them stable until it samples ready=1. It then drops sel or presents a new request.
- FSM states: IDLE, WAIT, RESP.
- IDLE: if any sel is high, accept a request at this edge.
  - One requester: grant it.
  - Both requesters: grant the port that was not granted last (round-robin).
  - Record the granted port in last_grant, which resets to HOST so the first tie goes to DMA.
  - Load wait_cnt = LAT-1. Go to RESP if LAT=1, otherwise go to WAIT.
- On the acceptance edge the array is accessed once.
  - In-range write: write the word.
  - In-range read: capture the word into the granted port's rdata register.
  - Out-of-range (addr >= MEM_DEPTH): the write is dropped, or ERR_WORD is captured, and the err flag for that port is set.
- WAIT: decrement wait_cnt each edge. At wait_cnt==1 go to RESP.
- RESP: the granted port's ready and err are high for exactly this cycle. Next edge: go to IDLE with ready and err cleared. No request is accepted in RESP.
- The non-granted port's ready is never asserted. Its rdata register holds its previous value.
- Ordering: the port granted first is accessed first. A host write followed by a DMA read of the same address returns the new data.
- sel dropped during WAIT (protocol violation): the transaction still completes and ready still pulses.
- Address and data changes after acceptance are ignored, because all fields are sampled at acceptance.
- Reset (async, any state):
  - state=IDLE, wait_cnt=0, last_grant=HOST.
  - mem_ready, host_ready, mem_err, host_err, and busy are 0.
  - mem_rdata and host_rdata are 32'h0.
  - Array contents are not cleared.
- An in-flight transaction aborted by reset produces no ready.
- A write accepted before the reset edge stays in the array.

## Timing
- Acceptance edge E0, with sel high in IDLE. ready is high in the cycle following edge E0+LAT-1, i.e. LAT cycles after E0.
- The earliest next acceptance is edge E0+LAT+1.
- Throughput per port, when uncontended: one transaction per LAT+1 cycles.
- busy rises in the cycle after E0 and falls after the RESP cycle.
- rdata is registered and valid exactly with ready, and it holds until the next read completes on that port.
- Both ports continuously requesting: grants alternate DMA, HOST, DMA, …, and each port completes every 2·(LAT+1) cycles.

## Test plan
- LAT=2, DMA write addr 0x010 data 0xA5A5_0001, then DMA read of 0x010:
  - mem_ready pulses 2 cycles after each acceptance.
  - Read returns 0xA5A5_0001 with mem_err=0.
  - host_ready stays 0.
- Both ports request in the same cycle (DMA read 0x020, host write 0x020=0x1234) straight out of reset:
  - DMA is granted first and reads the old value.
  - The host is then granted and completes LAT+1 cycles later.
  - A subsequent DMA read returns 0x1234.
- Sustained dual requests for 8 transactions: grants strictly alternate, ready never overlaps, and no ready appears on a non-requesting port.
- MEM_DEPTH=512:
  - Read of 0x200: mem_rdata=0xDEAD_BEEF with mem_err=1.
  - Write of 0x3FF: dropped, host_err=1.
  - A read of 0x1FF is unaffected.
- rst_n asserted during WAIT of a DMA write:
  - All outputs read zero immediately.
  - No mem_ready appears after release.
  - The next request is accepted normally with correct latency.
- LAT=1 and LAT=15 sweeps: ready arrives exactly LAT cycles after acceptance, is one cycle wide, and no second acceptance occurs in the RESP cycle while sel is still high.

Source files
------------

// File: rtl/boreal_dma_mem_resp.sv
// boreal_dma_mem_resp: round-robin DMA/host arbiter in front of a single-ported 32-bit word array.
// Latency: ready (with err, rdata) pulses for one cycle LAT cycles after the acceptance edge.
// Backpressure: one transaction in flight; requests wait (sel held) until the FSM is back in IDLE.
module boreal_dma_mem_resp #(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned LAT       = 2,
  parameter logic [31:0] ERR_WORD  = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_sel,
  input  logic        mem_wr,
  input  logic [9:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_err,
  input  logic        host_sel,
  input  logic        host_wr,
  input  logic [9:0]  host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_ready,
  output logic [31:0] host_rdata,
  output logic        host_err,
  output logic        busy
);

  localparam int unsigned AW       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0]  LOAD_CNT = 4'(LAT - 1);
  localparam logic        GRANT_DMA  = 1'b0;
  localparam logic        GRANT_HOST = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_wait_cnt;
  // Owner of the in-flight transaction; afterwards it is the previous grant for round-robin.
  logic        r_last_grant;
  logic        r_err;
  logic [31:0] r_mem_rdata;
  logic [31:0] r_host_rdata;
  logic [31:0] r_array [MEM_DEPTH];

  logic          w_accept;
  logic          w_pick_host;
  logic          w_wr;
  logic [9:0]    w_addr;
  logic [31:0]   w_wdata;
  logic          w_in_range;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rd_word;

  // Arbitration and request mux: host wins when alone, or on a tie when DMA had the last grant.
  always_comb begin
    w_accept    = (r_state == S_IDLE) && (mem_sel || host_sel);
    w_pick_host = host_sel && (!mem_sel || (r_last_grant == GRANT_DMA));
    w_wr        = w_pick_host ? host_wr    : mem_wr;
    w_addr      = w_pick_host ? host_addr  : mem_addr;
    w_wdata     = w_pick_host ? host_wdata : mem_wdata;
    w_in_range  = 32'(w_addr) < MEM_DEPTH;
    w_idx       = w_addr[AW-1:0];
    w_rd_word   = w_in_range ? r_array[w_idx] : ERR_WORD;
  end

  // State register with latency counter and grant record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= '0;
      r_last_grant <= GRANT_HOST;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_wait_cnt   <= LOAD_CNT;
        r_last_grant <= w_pick_host;
      end else if (r_state == S_WAIT) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
    end
  end

  // Next-state logic: IDLE accepts, WAIT counts down, RESP lasts exactly one cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = (LAT == 1) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_wait_cnt == 4'd1) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Array write at acceptance; out-of-range writes are dropped. Contents survive reset.
  always_ff @(posedge clk) begin
    if (w_accept && w_wr && w_in_range) r_array[w_idx] <= w_wdata;
  end

  // Read capture and error flag at acceptance; only the granted port's rdata changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err        <= 1'b0;
      r_mem_rdata  <= '0;
      r_host_rdata <= '0;
    end else if (w_accept) begin
      r_err <= !w_in_range;
      if (!w_wr) begin
        if (w_pick_host) r_host_rdata <= w_rd_word;
        else             r_mem_rdata  <= w_rd_word;
      end
    end
  end

  // Output decode: completion pulse and error go only to the port that owns the transaction.
  always_comb begin
    mem_ready  = (r_state == S_RESP) && (r_last_grant == GRANT_DMA);
    host_ready = (r_state == S_RESP) && (r_last_grant == GRANT_HOST);
    mem_err    = mem_ready && r_err;
    host_err   = host_ready && r_err;
    busy       = (r_state != S_IDLE);
  end

  assign mem_rdata  = r_mem_rdata;
  assign host_rdata = r_host_rdata;

endmodule

// File: tb/tb_boreal_dma_mem_resp.sv
// tb_boreal_dma_mem_resp: three responder instances (LAT=2/depth 512, LAT=1, LAT=15) driven
// by directed and random requests; expected results come from a word-array model that applies
// accesses in grant order, with round-robin and latency derived from the port-level rules.
module tb_boreal_dma_mem_resp;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [NI-1:0]       d_sel, d_wr, h_sel, h_wr;
  logic [NI-1:0][9:0]  d_addr, h_addr;
  logic [NI-1:0][31:0] d_wdata, h_wdata;
  logic [NI-1:0]       d_rdy, h_rdy, d_err, h_err, busy;
  logic [NI-1:0][31:0] d_rdata, h_rdata;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: word array per instance, expected rdata register per port, last grant.
  logic [31:0] model  [NI][1024];
  logic [31:0] exp_rd [NI][2];
  bit          lg_host[NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    boreal_dma_mem_resp #(
      .MEM_DEPTH(g == 0 ? 512 : 1024),
      .LAT      (g == 0 ? 2 : (g == 1 ? 1 : 15))
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_sel   (d_sel[g]),
      .mem_wr    (d_wr[g]),
      .mem_addr  (d_addr[g]),
      .mem_wdata (d_wdata[g]),
      .mem_ready (d_rdy[g]),
      .mem_rdata (d_rdata[g]),
      .mem_err   (d_err[g]),
      .host_sel  (h_sel[g]),
      .host_wr   (h_wr[g]),
      .host_addr (h_addr[g]),
      .host_wdata(h_wdata[g]),
      .host_ready(h_rdy[g]),
      .host_rdata(h_rdata[g]),
      .host_err  (h_err[g]),
      .busy      (busy[g])
    );
  end

  function automatic int lat_of(int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
  endfunction

  function automatic int depth_of(int k);
    return (k == 0) ? 512 : 1024;
  endfunction

  function automatic logic rdy_of(int k, bit p);
    return p ? h_rdy[k] : d_rdy[k];
  endfunction

  function automatic logic err_of(int k, bit p);
    return p ? h_err[k] : d_err[k];
  endfunction

  function automatic logic [31:0] rdata_of(int k, bit p);
    return p ? h_rdata[k] : d_rdata[k];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input int k, input bit p, input bit sel, input bit wr,
                       input logic [9:0] a, input logic [31:0] wd);
    if (p) begin
      h_sel[k] = sel; h_wr[k] = wr; h_addr[k] = a; h_wdata[k] = wd;
    end else begin
      d_sel[k] = sel; d_wr[k] = wr; d_addr[k] = a; d_wdata[k] = wd;
    end
  endtask

  // Apply one access to the model; returns the rdata and err the port must show at ready.
  task automatic model_access(input int k, input bit p, input bit wr, input logic [9:0] a,
                              input logic [31:0] wd, output logic [31:0] rd, output bit err);
    err = (int'(a) >= depth_of(k));
    if (wr) begin
      if (!err) model[k][a] = wd;
    end else begin
      exp_rd[k][p] = err ? 32'hDEAD_BEEF : model[k][a];
    end
    rd = exp_rd[k][p];
    lg_host[k] = p;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      lg_host[k] = 1'b1;
      exp_rd[k][0] = '0;
      exp_rd[k][1] = '0;
    end
  endtask

  task automatic rand_req(input int k, output bit wr, output logic [9:0] a, output logic [31:0] wd);
    wr = 1'($urandom_range(0, 1));
    if (depth_of(k) < 1024 && $urandom_range(0, 7) == 0)
      a = 10'(depth_of(k) + int'($urandom_range(0, 15)));
    else
      a = 10'($urandom_range(0, 15));
    wd = $urandom;
  endtask

  task automatic check_zero(input int k, input string tag);
    chk({tag, ".d_rdy"},   d_rdy[k],   0);
    chk({tag, ".h_rdy"},   h_rdy[k],   0);
    chk({tag, ".d_err"},   d_err[k],   0);
    chk({tag, ".h_err"},   h_err[k],   0);
    chk({tag, ".busy"},    busy[k],    0);
    chk({tag, ".d_rdata"}, d_rdata[k], 0);
    chk({tag, ".h_rdata"}, h_rdata[k], 0);
  endtask

  // Single request on an idle responder; starts and ends just after a falling edge.
  // sel stays high through the ready cycle to show RESP never accepts.
  task automatic do_req(input int k, input bit p, input bit wr, input logic [9:0] a,
                        input logic [31:0] wd, input string tag);
    int L;
    logic [31:0] erd, other;
    bit eerr;
    L = lat_of(k);
    other = exp_rd[k][~p];
    drive(k, p, 1'b1, wr, a, wd);
    model_access(k, p, wr, a, wd, erd, eerr);
    for (int n = 1; n <= L; n++) begin
      @(negedge clk);
      chk({tag, ".rdy"},   rdy_of(k, p), (n == L) ? 32'd1 : 32'd0);
      chk({tag, ".other"}, rdy_of(k, ~p), 0);
      chk({tag, ".busy"},  busy[k], 1);
    end
    chk({tag, ".rdata"},  rdata_of(k, p), erd);
    chk({tag, ".err"},    err_of(k, p), 32'(eerr));
    chk({tag, ".hold"},   rdata_of(k, ~p), other);
    @(negedge clk);
    chk({tag, ".after_rdy"},  rdy_of(k, p), 0);
    chk({tag, ".after_busy"}, busy[k], 0);
    drive(k, p, 1'b0, wr, a, wd);
  endtask

  // Both ports requesting; N transactions in total. Completions must alternate ports and
  // arrive L cycles after start, then every L+1 cycles.
  task automatic dual(input int k, input int N, input bit fixed,
                      input bit dwr, input logic [9:0] da, input logic [31:0] dwd,
                      input bit hwr, input logic [9:0] ha, input logic [31:0] hwd,
                      input string tag);
    int L, n, done, issued, next_at;
    bit nxt, eerr;
    bit pwr [2];
    logic [9:0] pa [2];
    logic [31:0] pwd [2];
    bit act [2];
    logic [31:0] erd;
    L = lat_of(k);
    if (fixed) begin
      pwr[0] = dwr; pa[0] = da; pwd[0] = dwd;
      pwr[1] = hwr; pa[1] = ha; pwd[1] = hwd;
    end else begin
      rand_req(k, pwr[0], pa[0], pwd[0]);
      rand_req(k, pwr[1], pa[1], pwd[1]);
    end
    for (int p = 0; p < 2; p++) begin
      act[p] = 1'b1;
      drive(k, 1'(p), 1'b1, pwr[p], pa[p], pwd[p]);
    end
    issued = 2; done = 0; n = 0; next_at = L;
    nxt = ~lg_host[k];
    while (done < N && n < N * (L + 1) + 4) begin
      @(negedge clk);
      n++;
      if (n == next_at) begin
        chk({tag, ".rdy"},  rdy_of(k, nxt), 1);
        chk({tag, ".excl"}, rdy_of(k, ~nxt), 0);
        model_access(k, nxt, pwr[nxt], pa[nxt], pwd[nxt], erd, eerr);
        chk({tag, ".rdata"}, rdata_of(k, nxt), erd);
        chk({tag, ".err"},   err_of(k, nxt), 32'(eerr));
        done++;
        if (issued < N) begin
          rand_req(k, pwr[nxt], pa[nxt], pwd[nxt]);
          drive(k, nxt, 1'b1, pwr[nxt], pa[nxt], pwd[nxt]);
          issued++;
        end else begin
          drive(k, nxt, 1'b0, pwr[nxt], pa[nxt], pwd[nxt]);
          act[nxt] = 1'b0;
        end
        if (act[~nxt]) nxt = ~nxt;
        next_at = n + L + 1;
      end else begin
        chk({tag, ".quiet"}, {rdy_of(k, 1'b0), rdy_of(k, 1'b1)}, 0);
      end
    end
    chk({tag, ".count"}, done, N);
    @(negedge clk);
    chk({tag, ".idle"}, {busy[k], d_rdy[k], h_rdy[k]}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] erd;
    bit eerr, p, wr;
    logic [9:0] a;
    logic [31:0] wd;

    d_sel = '0; d_wr = '0; d_addr = '0; d_wdata = '0;
    h_sel = '0; h_wr = '0; h_addr = '0; h_wdata = '0;
    model_reset();

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) check_zero(k, "reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Known contents for the random phases
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 16; i++)
        do_req(k, 1'(i), 1'b1, 10'(i), $urandom, "fill");

    // DMA write then read back, LAT=2
    do_req(0, 1'b0, 1'b1, 10'h010, 32'hA5A5_0001, "t1.wr");
    do_req(0, 1'b0, 1'b0, 10'h010, 32'h0, "t1.rd");
    chk("t1.value", d_rdata[0], 32'hA5A5_0001);

    // Tie straight out of reset: DMA read sees old word, host write lands after it
    do_req(0, 1'b0, 1'b1, 10'h020, 32'h5555_AAAA, "tie.pre");
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dual(0, 2, 1'b1, 1'b0, 10'h020, 32'h0, 1'b1, 10'h020, 32'h0000_1234, "tie");
    chk("tie.old", d_rdata[0], 32'h5555_AAAA);
    do_req(0, 1'b0, 1'b0, 10'h020, 32'h0, "tie.rd");
    chk("tie.new", d_rdata[0], 32'h0000_1234);

    // Sustained dual requests on every latency
    for (int k = 0; k < NI; k++) dual(k, 8, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, "sustain");

    // Out-of-range handling with MEM_DEPTH=512
    do_req(0, 1'b1, 1'b1, 10'h1FF, 32'hCAFE_0001, "oor.pre");
    do_req(0, 1'b0, 1'b0, 10'h200, 32'h0, "oor.rd");
    chk("oor.errword", d_rdata[0], 32'hDEAD_BEEF);
    do_req(0, 1'b1, 1'b1, 10'h3FF, 32'hBAD0_BAD0, "oor.wr");
    do_req(0, 1'b0, 1'b0, 10'h1FF, 32'h0, "oor.chk");
    chk("oor.intact", d_rdata[0], 32'hCAFE_0001);

    // Reset during WAIT of a DMA write
    drive(0, 1'b0, 1'b1, 1'b1, 10'h030, 32'h7777_0030);
    model_access(0, 1'b0, 1'b1, 10'h030, 32'h7777_0030, erd, eerr);
    @(negedge clk);
    chk("rstw.busy", busy[0], 1);
    chk("rstw.rdy", d_rdy[0], 0);
    rst_n = 1'b0;
    #1;
    check_zero(0, "rstw.async");
    drive(0, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstw.noready", {d_rdy[0], h_rdy[0], busy[0]}, 0);
    end
    do_req(0, 1'b0, 1'b0, 10'h030, 32'h0, "rstw.rd");
    chk("rstw.kept", d_rdata[0], 32'h7777_0030);

    // Random single-port sweeps, every instance
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 6; i++) begin
        p = 1'($urandom_range(0, 1));
        rand_req(k, wr, a, wd);
        do_req(k, p, wr, a, wd, "sweep");
      end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
